// File: rtl/atm_pkg.sv
// Shared definitions for the ATM ledger: opcodes, ledger FSM encoding and
// default sizing used by both the ledger arbiter and the terminal session FSMs.
package atm_pkg;

  typedef enum logic [1:0] {
    OP_BALANCE  = 2'b00,
    OP_WITHDRAW = 2'b01,
    OP_DEPOSIT  = 2'b10,
    OP_TRANSFER = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_WR_SRC,
    ST_WR_DST,
    ST_RESP
  } ledger_state_e;

  localparam int N_REQ_DEFAULT    = 4;
  localparam int N_ACC_DEFAULT    = 10;
  localparam int BAL_W_DEFAULT    = 16;
  localparam int AMT_W_DEFAULT    = 11;
  localparam int INIT_BAL_DEFAULT = 500;
  localparam int ACC_IDX_W        = 4;

endpackage

// File: rtl/atm_ledger_arbiter_if.sv
// Request/response bundle between the terminal session FSMs (master) and the
// ledger arbiter (slave); per-terminal fields are packed side by side.
interface atm_ledger_arbiter_if
  import atm_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int BAL_W = BAL_W_DEFAULT,
  parameter int AMT_W = AMT_W_DEFAULT
);

  logic [N_REQ-1:0]           req;
  logic [2*N_REQ-1:0]         op;
  logic [ACC_IDX_W*N_REQ-1:0] src_idx;
  logic [ACC_IDX_W*N_REQ-1:0] dst_idx;
  logic [AMT_W*N_REQ-1:0]     amount;
  logic [N_REQ-1:0]           gnt;
  logic [N_REQ-1:0]           done;
  logic                       rsp_err;
  logic [BAL_W-1:0]           rsp_balance;

  modport master (
    output req, op, src_idx, dst_idx, amount,
    input  gnt, done, rsp_err, rsp_balance
  );

  modport slave (
    input  req, op, src_idx, dst_idx, amount,
    output gnt, done, rsp_err, rsp_balance
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first asserted request at or after
// i_ptr (wrapping) wins; returns both one-hot and encoded winner.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  localparam int SUM_W = IDX_W + 1;

  logic [N_REQ-1:0] w_rot;
  logic [SUM_W-1:0] w_sum;
  logic             w_found;

  // Rotate so bit 0 is the terminal at i_ptr, then take the lowest set bit.
  always_comb begin
    w_rot   = N_REQ'({i_req, i_req} >> i_ptr);
    w_sum   = '0;
    w_found = 1'b0;
    o_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && w_rot[i]) begin
        w_found = 1'b1;
        w_sum   = SUM_W'(i_ptr) + SUM_W'(i);
        if (w_sum >= SUM_W'(N_REQ)) begin
          w_sum = w_sum - SUM_W'(N_REQ);
        end
        o_idx = w_sum[IDX_W-1:0];
      end
    end
    o_valid = w_found;
    o_grant = w_found ? (N_REQ'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/atm_ledger_arbiter.sv
// Shared balance ledger: serialises terminal requests round-robin and runs each
// as an atomic load/check/write sequence against the internal balance array.
module atm_ledger_arbiter
  import atm_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEFAULT,
  parameter int N_ACC    = N_ACC_DEFAULT,
  parameter int BAL_W    = BAL_W_DEFAULT,
  parameter int AMT_W    = AMT_W_DEFAULT,
  parameter int INIT_BAL = INIT_BAL_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  atm_ledger_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int SW    = BAL_W + 1;
  localparam logic [ACC_IDX_W-1:0] ACC_LIM = ACC_IDX_W'(N_ACC);

  ledger_state_e        r_state, w_next;
  logic [IDX_W-1:0]     r_ptr, r_win;
  logic [N_REQ-1:0]     r_win_oh;
  op_e                  r_op;
  logic [ACC_IDX_W-1:0] r_src, r_dst;
  logic [AMT_W-1:0]     r_amt;
  logic [SW-1:0]        r_bal_src, r_bal_dst;
  logic                 r_err, r_rsp_err;
  logic [BAL_W-1:0]     r_rsp_bal;
  logic [BAL_W-1:0]     r_ledger [N_ACC];

  logic [N_REQ-1:0]     w_arb_oh;
  logic [IDX_W-1:0]     w_arb_idx;
  logic                 w_arb_valid;
  logic [1:0]           w_op;
  logic [ACC_IDX_W-1:0] w_src, w_dst;
  logic [AMT_W-1:0]     w_amt;
  logic                 w_src_ok, w_dst_ok, w_err;
  logic [SW-1:0]        w_amt_ext, w_sum_src, w_sum_dst;
  logic [BAL_W-1:0]     w_new_src;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_oh),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  always_comb begin
    w_op  = '0;
    w_src = '0;
    w_dst = '0;
    w_amt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_arb_idx == IDX_W'(i)) begin
        w_op  = bus.op[2*i +: 2];
        w_src = bus.src_idx[ACC_IDX_W*i +: ACC_IDX_W];
        w_dst = bus.dst_idx[ACC_IDX_W*i +: ACC_IDX_W];
        w_amt = bus.amount[AMT_W*i +: AMT_W];
      end
    end
  end

  // Sums are one bit wider than a balance so overflow shows up in the MSB.
  assign w_src_ok  = (r_src < ACC_LIM);
  assign w_dst_ok  = (r_dst < ACC_LIM);
  assign w_amt_ext = SW'(r_amt);
  assign w_sum_src = r_bal_src + w_amt_ext;
  assign w_sum_dst = r_bal_dst + w_amt_ext;

  always_comb begin
    w_err = 1'b0;
    case (r_op)
      OP_WITHDRAW: w_err = (w_amt_ext > r_bal_src);
      OP_DEPOSIT:  w_err = w_sum_src[BAL_W];
      OP_TRANSFER: w_err = !w_dst_ok || (r_src == r_dst) ||
                           (w_amt_ext > r_bal_src) || w_sum_dst[BAL_W];
      default:     w_err = 1'b0;
    endcase
    if (!w_src_ok) begin
      w_err = 1'b1;
    end
  end

  always_comb begin
    w_new_src = r_bal_src[BAL_W-1:0];
    case (r_op)
      OP_WITHDRAW, OP_TRANSFER: w_new_src = BAL_W'(r_bal_src - w_amt_ext);
      OP_DEPOSIT:               w_new_src = w_sum_src[BAL_W-1:0];
      default:                  w_new_src = r_bal_src[BAL_W-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_arb_valid) w_next = ST_LOAD;
      ST_LOAD:   w_next = ST_CHECK;
      ST_CHECK:  w_next = ST_WR_SRC;
      ST_WR_SRC: w_next = (r_op == OP_TRANSFER && !r_err) ? ST_WR_DST : ST_RESP;
      ST_WR_DST: w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= '0;
      r_win     <= '0;
      r_win_oh  <= '0;
      r_op      <= OP_BALANCE;
      r_src     <= '0;
      r_dst     <= '0;
      r_amt     <= '0;
      r_bal_src <= '0;
      r_bal_dst <= '0;
      r_err     <= 1'b0;
      r_rsp_err <= 1'b0;
      r_rsp_bal <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_arb_valid) begin
            r_win    <= w_arb_idx;
            r_win_oh <= w_arb_oh;
            r_op     <= op_e'(w_op);
            r_src    <= w_src;
            r_dst    <= w_dst;
            r_amt    <= w_amt;
          end
        end
        ST_LOAD: begin
          r_bal_src <= w_src_ok ? SW'(r_ledger[r_src]) : '0;
          r_bal_dst <= w_dst_ok ? SW'(r_ledger[r_dst]) : '0;
        end
        ST_CHECK:  r_err <= w_err;
        ST_WR_SRC: begin
          r_rsp_err <= r_err;
          r_rsp_bal <= r_err ? r_bal_src[BAL_W-1:0] : w_new_src;
        end
        ST_RESP:   r_ptr <= (r_win == IDX_W'(N_REQ-1)) ? '0 : r_win + 1'b1;
        default:   ;
      endcase
    end
  end

  // Single write port: a transfer spends WR_SRC and WR_DST on its two writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < N_ACC; a++) begin
        r_ledger[a] <= BAL_W'(INIT_BAL);
      end
    end else if (r_state == ST_WR_SRC && !r_err && r_op != OP_BALANCE) begin
      r_ledger[r_src] <= w_new_src;
    end else if (r_state == ST_WR_DST) begin
      r_ledger[r_dst] <= w_sum_dst[BAL_W-1:0];
    end
  end

  assign bus.gnt         = (r_state != ST_IDLE) ? r_win_oh : '0;
  assign bus.done        = (r_state == ST_RESP) ? r_win_oh : '0;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.rsp_balance = r_rsp_bal;

endmodule

// File: tb/tb_atm_ledger_arbiter.sv
// Directed bench for atm_ledger_arbiter: a vector table of single-terminal
// operations plus hand-written overflow, contention and mid-operation reset runs.
module tb_atm_ledger_arbiter;
  import atm_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nCompared = 0;
  int   nMismatch = 0;

  always #5 clk = ~clk;

  atm_ledger_arbiter_if bus ();

  atm_ledger_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int   term;
    op_e  op;
    int   src;
    int   dst;
    int   amt;
    logic expErr;
    int   expBal;
    int   expLat;
  } vec_t;

  vec_t vecs [19];

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Issues one operation from one terminal and checks latency and response.
  task automatic applyStimulus(input int term, input op_e op, input int src, input int dst,
                               input int amt, input logic expErr, input int expBal,
                               input int expLat, input string name);
    int lat;
    bit seen;
    @(negedge clk);
    bus.req                  = '0;
    bus.op[2*term +: 2]      = op;
    bus.src_idx[4*term +: 4] = src[3:0];
    bus.dst_idx[4*term +: 4] = dst[3:0];
    bus.amount[11*term +: 11] = amt[10:0];
    bus.req[term]            = 1'b1;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.done != '0) seen = 1'b1;
    end
    if (!seen) begin
      checkOutput({name, "_timeout"}, lat, expLat);
    end else begin
      checkOutput({name, "_latency"}, lat, expLat);
      checkOutput({name, "_done"}, bus.done, 1 << term);
      checkOutput({name, "_gnt"}, bus.gnt, 1 << term);
      checkOutput({name, "_err"}, bus.rsp_err, expErr);
      checkOutput({name, "_balance"}, bus.rsp_balance, expBal);
    end
    bus.req = '0;
  endtask

  task automatic checkIdleOutputs(input string name);
    checkOutput({name, "_gnt"}, bus.gnt, 0);
    checkOutput({name, "_done"}, bus.done, 0);
    checkOutput({name, "_err"}, bus.rsp_err, 0);
    checkOutput({name, "_balance"}, bus.rsp_balance, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneCyc [5];
    int doneIdx [5];
    int nDone;
    int cyc;

    bus.req     = '0;
    bus.op      = '0;
    bus.src_idx = '0;
    bus.dst_idx = '0;
    bus.amount  = '0;

    vecs[0]  = '{0, OP_BALANCE,  3, 0,    0, 1'b0,  500, 4};
    vecs[1]  = '{1, OP_WITHDRAW, 2, 0,  200, 1'b0,  300, 4};
    vecs[2]  = '{1, OP_WITHDRAW, 2, 0,  400, 1'b1,  300, 4};
    vecs[3]  = '{0, OP_BALANCE,  2, 0,    0, 1'b0,  300, 4};
    vecs[4]  = '{2, OP_TRANSFER, 1, 4,  100, 1'b0,  400, 5};
    vecs[5]  = '{3, OP_BALANCE,  4, 0,    0, 1'b0,  600, 4};
    vecs[6]  = '{3, OP_BALANCE,  1, 0,    0, 1'b0,  400, 4};
    vecs[7]  = '{2, OP_TRANSFER, 5, 5,   10, 1'b1,  500, 4};
    vecs[8]  = '{2, OP_TRANSFER, 5, 12,  10, 1'b1,  500, 4};
    vecs[9]  = '{0, OP_BALANCE,  5, 0,    0, 1'b0,  500, 4};
    vecs[10] = '{1, OP_BALANCE, 10, 0,    0, 1'b1,    0, 4};
    vecs[11] = '{1, OP_WITHDRAW,15, 0,    5, 1'b1,    0, 4};
    vecs[12] = '{3, OP_TRANSFER, 8, 9,  600, 1'b1,  500, 4};
    vecs[13] = '{3, OP_WITHDRAW, 9, 0,  500, 1'b0,    0, 4};
    vecs[14] = '{0, OP_WITHDRAW, 9, 0,    1, 1'b1,    0, 4};
    vecs[15] = '{0, OP_BALANCE,  8, 0,    0, 1'b0,  500, 4};
    vecs[16] = '{2, OP_DEPOSIT,  0, 0, 2047, 1'b0, 2547, 4};
    vecs[17] = '{1, OP_TRANSFER,10, 0,    5, 1'b1,    0, 4};
    vecs[18] = '{1, OP_BALANCE,  0, 0,    0, 1'b0, 2547, 4};

    repeat (2) @(negedge clk);
    checkIdleOutputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].term, vecs[i].op, vecs[i].src, vecs[i].dst, vecs[i].amt,
                    vecs[i].expErr, vecs[i].expBal, vecs[i].expLat, $sformatf("vec%0d", i));
    end

    // Fill account 6 to 65500, then probe both overflow limits.
    for (int k = 1; k <= 31; k++) begin
      applyStimulus(k % 4, OP_DEPOSIT, 6, 0, 2047, 1'b0, 500 + k * 2047, 4,
                    $sformatf("fill%0d", k));
    end
    applyStimulus(0, OP_DEPOSIT, 6, 0, 1543, 1'b0, 65500, 4, "fill_last");
    applyStimulus(1, OP_TRANSFER, 7, 6, 100, 1'b1, 500, 4, "xfer_dst_ovf");
    applyStimulus(2, OP_BALANCE, 6, 0, 0, 1'b0, 65500, 4, "bal6_after_ovf");
    applyStimulus(3, OP_BALANCE, 7, 0, 0, 1'b0, 500, 4, "bal7_after_ovf");
    applyStimulus(0, OP_DEPOSIT, 6, 0, 36, 1'b1, 65500, 4, "dep_ovf");
    applyStimulus(1, OP_DEPOSIT, 6, 0, 35, 1'b0, 65535, 4, "dep_max");

    // Reset returns the pointer to 0, then all four terminals contend.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkIdleOutputs("reset2");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 4; t++) begin
      bus.op[2*t +: 2]       = OP_BALANCE;
      bus.src_idx[4*t +: 4]  = 4'(t);
      bus.dst_idx[4*t +: 4]  = '0;
      bus.amount[11*t +: 11] = '0;
    end
    bus.req = 4'b1111;
    nDone = 0;
    cyc   = 0;
    while (nDone < 5 && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (bus.done != '0) begin
        doneCyc[nDone] = cyc;
        doneIdx[nDone] = 0;
        for (int t = 0; t < 4; t++) if (bus.done[t]) doneIdx[nDone] = t;
        checkOutput($sformatf("rr%0d_balance", nDone), bus.rsp_balance, 500);
        nDone++;
      end
    end
    bus.req = '0;
    checkOutput("rr_count", nDone, 5);
    for (int n = 0; n < nDone; n++) begin
      checkOutput($sformatf("rr%0d_winner", n), doneIdx[n], n % 4);
      checkOutput($sformatf("rr%0d_cycle", n), doneCyc[n], 4 + 5 * n);
    end

    // Reset while a transfer sits in WR_DST.
    @(negedge clk);
    bus.op[1:0]      = OP_TRANSFER;
    bus.src_idx[3:0] = 4'd1;
    bus.dst_idx[3:0] = 4'd2;
    bus.amount[10:0] = 11'd100;
    bus.req          = 4'b0001;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("wrdst_gnt", bus.gnt, 1);
    checkOutput("wrdst_done", bus.done, 0);
    rst_n = 1'b0;
    #1;
    checkIdleOutputs("wrdst_reset");
    bus.req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2, OP_BALANCE, 1, 0, 0, 1'b0, 500, 4, "post_rst_src");
    applyStimulus(3, OP_BALANCE, 2, 0, 0, 1'b0, 500, 4, "post_rst_dst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
